// File: rtl/ex_hilo_if.sv
// EX-stage HI/LO bus: operation request and read-select inputs, plus the
// busy/stall handshake and architectural HI/LO outputs.
interface ex_hilo_if;
    logic        iHiLoWrite;
    logic [5:0]  iFun;
    logic [31:0] iRegOut1;
    logic [31:0] iRegOut2;
    logic        iRead;
    logic        iHL;
    logic        oBusy;
    logic        oStall;
    logic [31:0] oResult;
    logic [31:0] oHi;
    logic [31:0] oLo;

    modport master (
        output iHiLoWrite, iFun, iRegOut1, iRegOut2, iRead, iHL,
        input  oBusy, oStall, oResult, oHi, oLo
    );

    modport slave (
        input  iHiLoWrite, iFun, iRegOut1, iRegOut2, iRead, iHL,
        output oBusy, oStall, oResult, oHi, oLo
    );
endinterface

// File: rtl/ex_hilo.sv
// HI/LO unit: 33-cycle iterative multiply / restoring divide, MTHI/MTLO,
// and MFHI/MFLO read port with a combinational stall towards the pipeline.
module ex_hilo (
    input  logic     clk,
    input  logic     rst,
    ex_hilo_if.slave bus
);
    localparam int DATA_W = 32;

    localparam logic [5:0] FUN_MULT  = 6'h18;
    localparam logic [5:0] FUN_MULTU = 6'h19;
    localparam logic [5:0] FUN_DIV   = 6'h1A;
    localparam logic [5:0] FUN_DIVU  = 6'h1B;
    localparam logic [5:0] FUN_MTHI  = 6'h11;
    localparam logic [5:0] FUN_MTLO  = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t              state_q;
    logic                busy_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [5:0]          cnt_q;
    logic                neg_q;
    logic                rneg_q;
    logic                div_q;
    logic                dz_q;

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction

    function automatic logic [2*DATA_W-1:0] negate_wide(input logic [2*DATA_W-1:0] v);
        return ~v + 1'b1;
    endfunction

    // 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                    input logic is_signed);
        return (is_signed && (v < 0)) ? negate(v) : v;
    endfunction

    logic                op_mdu_d;
    logic                op_div_d;
    logic                op_signed_d;
    logic [DATA_W-1:0]   mag1_d;
    logic [DATA_W-1:0]   mag2_d;

    always_comb begin
        op_mdu_d    = (bus.iFun == FUN_MULT) || (bus.iFun == FUN_MULTU) ||
                      (bus.iFun == FUN_DIV)  || (bus.iFun == FUN_DIVU);
        op_div_d    = (bus.iFun == FUN_DIV)  || (bus.iFun == FUN_DIVU);
        op_signed_d = (bus.iFun == FUN_MULT) || (bus.iFun == FUN_DIV);
        mag1_d      = magnitude(bus.iRegOut1, op_signed_d);
        mag2_d      = magnitude(bus.iRegOut2, op_signed_d);
    end

    logic [DATA_W:0]     mul_sum_d;
    logic [2*DATA_W-1:0] mul_acc_d;
    logic [DATA_W:0]     div_rem_d;
    logic [DATA_W:0]     div_diff_d;
    logic [2*DATA_W-1:0] div_acc_d;

    // acc_q holds {partial product, multiplier} for MUL and
    // {partial remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum_d  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_acc_d  = {mul_sum_d, acc_q[DATA_W-1:1]};
        div_rem_d  = acc_q[2*DATA_W-1:DATA_W-1];
        div_diff_d = div_rem_d - {1'b0, b_q};
        if (div_rem_d >= {1'b0, b_q}) begin
            div_acc_d = {div_diff_d[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end else begin
            div_acc_d = {div_rem_d[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end
    end

    logic [2*DATA_W-1:0] prod_d;
    logic [DATA_W-1:0]   fix_hi_d;
    logic [DATA_W-1:0]   fix_lo_d;

    always_comb begin
        prod_d   = neg_q ? negate_wide(acc_q) : acc_q;
        fix_hi_d = prod_d[2*DATA_W-1:DATA_W];
        fix_lo_d = prod_d[DATA_W-1:0];
        if (div_q) begin
            if (dz_q) begin
                // Rebuild the original dividend from its magnitude and sign.
                fix_hi_d = rneg_q ? negate(a_q) : a_q;
                fix_lo_d = '1;
            end else begin
                fix_hi_d = rneg_q ? negate(acc_q[2*DATA_W-1:DATA_W]) : acc_q[2*DATA_W-1:DATA_W];
                fix_lo_d = neg_q ? negate(acc_q[DATA_W-1:0]) : acc_q[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.iHiLoWrite) begin
                        if (bus.iFun == FUN_MTHI) begin
                            hi_q <= bus.iRegOut1;
                        end else if (bus.iFun == FUN_MTLO) begin
                            lo_q <= bus.iRegOut1;
                        end else if (op_mdu_d) begin
                            a_q     <= mag1_d;
                            b_q     <= mag2_d;
                            acc_q   <= {{DATA_W{1'b0}}, (op_div_d ? mag1_d : mag2_d)};
                            neg_q   <= op_signed_d & (bus.iRegOut1[DATA_W-1] ^ bus.iRegOut2[DATA_W-1]);
                            rneg_q  <= op_signed_d & bus.iRegOut1[DATA_W-1];
                            div_q   <= op_div_d;
                            dz_q    <= (bus.iRegOut2 == '0);
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= op_div_d ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= S_FIX;
                end
                S_DIV: begin
                    acc_q <= div_acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= S_FIX;
                end
                S_FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oBusy   = busy_q;
    assign bus.oStall  = busy_q & (bus.iHiLoWrite | bus.iRead);
    assign bus.oResult = bus.iRead ? (bus.iHL ? hi_q : lo_q) : '0;
    assign bus.oHi     = hi_q;
    assign bus.oLo     = lo_q;
endmodule

// File: tb/tb_ex_hilo.sv
// Directed bench for ex_hilo: MTHI/MTLO, signed/unsigned multiply and divide,
// divide-by-zero, stall behaviour while busy, and asynchronous abort.
module tb_ex_hilo;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MFHI  = 6'h10;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ex_hilo_if bus();
    ex_hilo dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the request is taken on the next rising edge.
    task automatic issue(input logic [5:0] fun, input logic [31:0] rs, input logic [31:0] rt);
        bus.iHiLoWrite = 1'b1;
        bus.iFun       = fun;
        bus.iRegOut1   = rs;
        bus.iRegOut2   = rt;
        @(negedge clk);
        bus.iHiLoWrite = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.oBusy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] fun,
                          input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] eh, input logic [31:0] el);
        int n;
        issue(fun, rs, rt);
        wait_idle(n);
        check({tag, "_busy_cycles"}, n, 32'd33);
        check({tag, "_hi"}, bus.oHi, eh);
        check({tag, "_lo"}, bus.oLo, el);
    endtask

    initial begin
        int n;
        rst            = 1'b1;
        bus.iHiLoWrite = 1'b0;
        bus.iFun       = '0;
        bus.iRegOut1   = '0;
        bus.iRegOut2   = '0;
        bus.iRead      = 1'b1;
        bus.iHL        = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_hi", bus.oHi, 32'h0);
        check("rst_lo", bus.oLo, 32'h0);
        check("rst_busy", {31'b0, bus.oBusy}, 32'h0);
        check("rst_stall", {31'b0, bus.oStall}, 32'h0);
        check("rst_result", bus.oResult, 32'h0);
        rst       = 1'b0;
        bus.iRead = 1'b0;
        @(negedge clk);

        issue(F_MTLO, 32'h12345678, 32'h0);
        check("mtlo_lo", bus.oLo, 32'h12345678);
        check("mtlo_hi", bus.oHi, 32'h0);
        check("mtlo_busy", {31'b0, bus.oBusy}, 32'h0);
        issue(F_MTHI, 32'hA5A5A5A5, 32'h0);
        check("mthi_hi", bus.oHi, 32'hA5A5A5A5);
        issue(F_MFHI, 32'hDEADBEEF, 32'h0);
        check("nop_hi", bus.oHi, 32'hA5A5A5A5);
        check("nop_lo", bus.oLo, 32'h12345678);
        check("nop_busy", {31'b0, bus.oBusy}, 32'h0);

        bus.iRead = 1'b1; bus.iHL = 1'b1; #1;
        check("read_hi", bus.oResult, 32'hA5A5A5A5);
        bus.iHL = 1'b0; #1;
        check("read_lo", bus.oResult, 32'h12345678);
        bus.iRead = 1'b0; #1;
        check("read_off", bus.oResult, 32'h0);
        @(negedge clk);

        run_op("mult_neg",   F_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA);
        run_op("multu_max",  F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_2neg",  F_MULT,  32'hFFFFFFFD, 32'hFFFFFFFC, 32'h0,        32'd12);
        run_op("div_neg7",   F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_negdiv", F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
        run_op("divu_zero",  F_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF);
        run_op("div_zero",   F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
        run_op("div_ovf",    F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
        run_op("divu_big",   F_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF);

        // MFHI arriving at cycle 5 of a divide: held until HI carries the remainder.
        issue(F_DIV, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        bus.iRead = 1'b1; bus.iHL = 1'b1;
        n = 0;
        while (bus.oBusy === 1'b1 && n < 100) begin
            #1;
            check("mfhi_stall", {31'b0, bus.oStall}, 32'h1);
            check("mfhi_hold_hi", bus.oHi, 32'd15);
            n++;
            @(negedge clk);
        end
        check("mfhi_wait", n, 32'd29);
        #1;
        check("mfhi_unstall", {31'b0, bus.oStall}, 32'h0);
        check("mfhi_result", bus.oResult, 32'd2);
        bus.iHL = 1'b0; #1;
        check("mflo_result", bus.oResult, 32'd14);
        bus.iRead = 1'b0;
        @(negedge clk);

        // MTLO held from cycle 3 of a multiply; taken one edge after the write-back.
        issue(F_MULTU, 32'd2, 32'd3);
        n = 0;
        while (bus.oBusy === 1'b1 && n < 100) begin
            if (n == 2) begin
                bus.iHiLoWrite = 1'b1;
                bus.iFun       = F_MTLO;
                bus.iRegOut1   = 32'hCAFEF00D;
                #1;
            end
            if (n >= 2) begin
                check("mtlo_busy_stall", {31'b0, bus.oStall}, 32'h1);
                check("mtlo_busy_lo", bus.oLo, 32'd14);
            end
            n++;
            @(negedge clk);
        end
        check("mtlo_busy_cycles", n, 32'd33);
        check("mtlo_after_fix_lo", bus.oLo, 32'd6);
        check("mtlo_after_fix_hi", bus.oHi, 32'd0);
        check("mtlo_after_fix_stall", {31'b0, bus.oStall}, 32'h0);
        @(negedge clk);
        bus.iHiLoWrite = 1'b0;
        check("mtlo_accepted_lo", bus.oLo, 32'hCAFEF00D);
        check("mtlo_accepted_busy", {31'b0, bus.oBusy}, 32'h0);

        // Asynchronous abort at cycle 10 of a multiply.
        issue(F_MTHI, 32'h0BADF00D, 32'h0);
        issue(F_MULT, 32'd5, 32'd7);
        repeat (9) @(negedge clk);
        bus.iRead = 1'b1; bus.iHL = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, bus.oBusy}, 32'h0);
        check("abort_hi", bus.oHi, 32'h0);
        check("abort_lo", bus.oLo, 32'h0);
        check("abort_stall", {31'b0, bus.oStall}, 32'h0);
        check("abort_result", bus.oResult, 32'h0);
        @(negedge clk);
        rst       = 1'b0;
        bus.iRead = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_write_hi", bus.oHi, 32'h0);
        check("abort_no_write_lo", bus.oLo, 32'h0);
        run_op("post_abort_multu", F_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
